text_writer: RTL and testbench

Writer end of the VGA text path. It accepts one ASCII byte at a time from the CPU/IO side over a valid/ready handshake and maintains the 64×11 character buffer and cursor. It also interprets control codes and scrolls the screen. The buffer is exported as `text[703:0]` and drives the pixel renderer directly.

---
 rtl/text_pkg.sv | 33 +++
 rtl/text_writer_if.sv | 11 +
 rtl/text_writer.sv | 121 ++++++++++++
 tb/tb_text_writer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared geometry, character codes and state encoding for the text path.
// The renderer imports this package for COLS/CHARS as well.
package text_pkg;

    localparam int COLS  = 64;
    localparam int ROWS  = 11;
    localparam int CHARS = COLS * ROWS;

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int IDX_W = COL_W + ROW_W;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} tw_state_t;

    function automatic logic isPrintable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    // COLS is a power of two, so a row's first buffer index is just {row, 0}.
    function automatic logic [IDX_W-1:0] rowBase(input logic [ROW_W-1:0] r);
        return {r, {COL_W{1'b0}}};
    endfunction

endpackage

// File: rtl/text_writer_if.sv
// Byte-wide valid/ready channel from the CPU/IO side into the text writer.
interface text_writer_if;

    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;

    modport master (output in_valid, output in_char, input in_ready);
    modport slave  (input in_valid, input in_char, output in_ready);

endinterface

// File: rtl/text_writer.sv
// Character buffer and cursor for the VGA text path: prints bytes, handles
// CR/LF/BS/FF and scrolls or clears one row per cycle while busy.
module text_writer
    import text_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    text_writer_if.slave          host,
    output logic [CHARS-1:0][7:0] text,
    output logic [COL_W-1:0]      cur_col,
    output logic [ROW_W-1:0]      cur_row,
    output logic                  busy
);

    tw_state_t        state;
    logic [ROW_W-1:0] rowCnt;
    logic             ready;
    logic             accept;
    logic             rowAdvance;
    logic [IDX_W-1:0] curIdx;

    assign accept        = host.in_valid && ready;
    assign host.in_ready = ready;
    assign busy          = ~ready;
    assign curIdx        = {cur_row, cur_col};

    // Column wrap and LF both move the cursor to the next row.
    always_comb begin
        rowAdvance = 1'b0;
        if (accept) begin
            if (isPrintable(host.in_char)) begin
                rowAdvance = (cur_col == COL_MAX);
            end else if (host.in_char == CH_LF) begin
                rowAdvance = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready   <= 1'b1;
            rowCnt  <= '0;
            cur_col <= '0;
            cur_row <= '0;
            text    <= {CHARS{BLANK}};
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (isPrintable(host.in_char)) begin
                            text[curIdx] <= host.in_char;
                            cur_col      <= cur_col + 1'b1;
                        end else begin
                            case (host.in_char)
                                CH_CR: cur_col <= '0;
                                CH_LF: cur_col <= '0;
                                CH_BS: begin
                                    // The new cursor cell is always curIdx-1, even across a row boundary.
                                    if (curIdx != '0) begin
                                        text[curIdx - 1'b1] <= BLANK;
                                        cur_col             <= cur_col - 1'b1;
                                        if (cur_col == '0) begin
                                            cur_row <= cur_row - 1'b1;
                                        end
                                    end
                                end
                                CH_FF: begin
                                    state  <= CLEAR;
                                    ready  <= 1'b0;
                                    rowCnt <= '0;
                                end
                                default: ;
                            endcase
                        end
                        if (rowAdvance) begin
                            if (cur_row == ROW_MAX) begin
                                state  <= SCROLL;
                                ready  <= 1'b0;
                                rowCnt <= '0;
                            end else begin
                                cur_row <= cur_row + 1'b1;
                            end
                        end
                    end
                end

                SCROLL: begin
                    if (rowCnt == ROW_MAX) begin
                        text[rowBase(rowCnt) +: COLS] <= {COLS{BLANK}};
                        state                         <= IDLE;
                        ready                         <= 1'b1;
                    end else begin
                        text[rowBase(rowCnt) +: COLS] <= text[rowBase(rowCnt + 1'b1) +: COLS];
                        rowCnt                        <= rowCnt + 1'b1;
                    end
                end

                CLEAR: begin
                    text[rowBase(rowCnt) +: COLS] <= {COLS{BLANK}};
                    if (rowCnt == '0) begin
                        cur_col <= '0;
                        cur_row <= '0;
                    end
                    if (rowCnt == ROW_MAX) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        rowCnt <= rowCnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer: directed scenarios plus random byte
// streams compared against a screen-level reference model.
`timescale 1ns/1ps
module tb_text_writer;
    import text_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [CHARS-1:0][7:0] textOut;
    logic [COL_W-1:0]      curCol;
    logic [ROW_W-1:0]      curRow;
    logic                  busy;

    text_writer_if hostIf();

    text_writer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (hostIf),
        .text    (textOut),
        .cur_col (curCol),
        .cur_row (curRow),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference screen: scroll/clear take effect instantly; busyLeft counts the
    // cycles the writer must still refuse input.
    logic [7:0] mem [CHARS];
    int         mRow;
    int         mCol;
    int         busyLeft;
    logic       lastReady;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < CHARS; i++) mem[i] = BLANK;
        mRow     = 0;
        mCol     = 0;
        busyLeft = 0;
    endtask

    task automatic modelNextRow();
        if (mRow < ROWS - 1) begin
            mRow++;
        end else begin
            for (int i = 0; i < (ROWS - 1) * COLS; i++) mem[i] = mem[i + COLS];
            for (int i = (ROWS - 1) * COLS; i < CHARS; i++) mem[i] = BLANK;
            busyLeft = ROWS;
        end
    endtask

    task automatic modelApply(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            mem[mRow * COLS + mCol] = c;
            mCol++;
            if (mCol == COLS) begin
                mCol = 0;
                modelNextRow();
            end
        end else if (c == CH_CR) begin
            mCol = 0;
        end else if (c == CH_LF) begin
            mCol = 0;
            modelNextRow();
        end else if (c == CH_BS) begin
            if (mRow != 0 || mCol != 0) begin
                if (mCol > 0) begin
                    mCol--;
                end else begin
                    mRow--;
                    mCol = COLS - 1;
                end
                mem[mRow * COLS + mCol] = BLANK;
            end
        end else if (c == CH_FF) begin
            for (int i = 0; i < CHARS; i++) mem[i] = BLANK;
            mRow     = 0;
            mCol     = 0;
            busyLeft = ROWS;
        end
    endtask

    task automatic compareAll();
        int diff;
        int first;
        checkEq("in_ready", 32'(hostIf.in_ready), 32'(busyLeft == 0));
        checkEq("busy", 32'(busy), 32'(busyLeft != 0));
        if (busyLeft == 0) begin
            checkEq("cur_col", 32'(curCol), 32'(mCol));
            checkEq("cur_row", 32'(curRow), 32'(mRow));
            diff  = 0;
            first = -1;
            for (int i = 0; i < CHARS; i++) begin
                if (textOut[i] !== mem[i]) begin
                    diff++;
                    if (first < 0) first = i;
                end
            end
            checkEq($sformatf("text_diff(first@%0d)", first), 32'(diff), 32'd0);
        end
    endtask

    // One clock: check the state left by the previous edge, then drive the next
    // inputs and advance the model by the edge that will consume them.
    task automatic driveCycle(input logic v, input logic [7:0] c);
        @(negedge clk);
        compareAll();
        lastReady       = hostIf.in_ready;
        hostIf.in_valid = v;
        hostIf.in_char  = c;
        if (busyLeft > 0) busyLeft--;
        else if (v) modelApply(c);
    endtask

    task automatic sendByte(input logic [7:0] c);
        logic wasReady;
        do begin
            wasReady = (busyLeft == 0);
            driveCycle(1'b1, c);
        end while (!wasReady);
    endtask

    task automatic measureBusy(input logic v, input logic [7:0] c, output int low);
        low = 0;
        for (int i = 0; i < 30; i++) begin
            driveCycle(v, c);
            if (!lastReady) low++;
            else if (low > 0) break;
        end
    endtask

    task automatic countNonBlank(output int n);
        n = 0;
        for (int i = 0; i < CHARS; i++) if (textOut[i] !== BLANK) n++;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2;
        rst_n           = 1'b0;
        hostIf.in_valid = 1'b0;
        modelReset();
        #1;
        compareAll();
        @(negedge clk);
        compareAll();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] randChar();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 60) return 8'($urandom_range(32, 126));
        if (r < 72) return CH_LF;
        if (r < 80) return CH_BS;
        if (r < 86) return CH_CR;
        if (r < 88) return CH_FF;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int low;
        int n;
        rst_n           = 1'b0;
        hostIf.in_valid = 1'b0;
        hostIf.in_char  = 8'h00;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compareAll();
        rst_n = 1'b1;

        // "HI" back to back
        sendByte(8'h48);
        sendByte(8'h49);
        driveCycle(1'b0, 8'h00);
        checkEq("hi_text0", 32'(textOut[0]), 32'h48);
        checkEq("hi_text1", 32'(textOut[1]), 32'h49);
        checkEq("hi_col", 32'(curCol), 32'd2);
        checkEq("hi_ready", 32'(hostIf.in_ready), 32'd1);
        $display("txn: HI written, cursor (%0d,%0d)", curRow, curCol);

        // 64 x 'A' from (0,0) wraps to (1,0)
        sendByte(CH_CR);
        for (int i = 0; i < COLS; i++) sendByte(8'h41);
        driveCycle(1'b0, 8'h00);
        checkEq("wrap_row", 32'(curRow), 32'd1);
        checkEq("wrap_col", 32'(curCol), 32'd0);
        checkEq("wrap_text63", 32'(textOut[63]), 32'h41);
        $display("txn: 64 x A, cursor (%0d,%0d)", curRow, curCol);

        // 'Q' at (1,0), go to row 10, partial fill, LF scrolls while 'X' is held
        sendByte(8'h51);
        for (int i = 0; i < ROWS - 2; i++) sendByte(CH_LF);
        for (int i = 0; i < 10; i++) sendByte(8'h5A);
        sendByte(CH_LF);
        measureBusy(1'b1, 8'h58, low);
        checkEq("scroll_busy", 32'(low), 32'd11);
        driveCycle(1'b0, 8'h00);
        checkEq("scroll_text0", 32'(textOut[0]), 32'h51);
        checkEq("scroll_x", 32'(textOut[640]), 32'h58);
        checkEq("scroll_blank", 32'(textOut[641]), 32'h20);
        checkEq("scroll_row", 32'(curRow), 32'd10);
        checkEq("scroll_col", 32'(curCol), 32'd1);
        $display("txn: LF at row 10, busy %0d cycles", low);

        // clear, BS at origin, BS across a row boundary
        sendByte(CH_FF);
        measureBusy(1'b0, 8'h00, low);
        checkEq("clear_busy", 32'(low), 32'd11);
        sendByte(CH_BS);
        driveCycle(1'b0, 8'h00);
        checkEq("bs0_col", 32'(curCol), 32'd0);
        checkEq("bs0_row", 32'(curRow), 32'd0);
        sendByte(CH_LF);
        for (int i = 0; i < COLS - 1; i++) sendByte(8'h2E);
        sendByte(8'h4B);
        sendByte(CH_BS);
        driveCycle(1'b0, 8'h00);
        checkEq("bs_row", 32'(curRow), 32'd1);
        checkEq("bs_col", 32'(curCol), 32'd63);
        checkEq("bs_text127", 32'(textOut[127]), 32'h20);
        checkEq("bs_text126", 32'(textOut[126]), 32'h2E);
        $display("txn: BS over row boundary, cursor (%0d,%0d)", curRow, curCol);

        // nearly full screen, then FF
        sendByte(CH_FF);
        for (int i = 0; i < CHARS - 1; i++) sendByte(8'($urandom_range(33, 126)));
        sendByte(CH_FF);
        measureBusy(1'b0, 8'h00, low);
        checkEq("ff_busy", 32'(low), 32'd11);
        countNonBlank(n);
        checkEq("ff_nonblank", 32'(n), 32'd0);
        checkEq("ff_row", 32'(curRow), 32'd0);
        checkEq("ff_col", 32'(curCol), 32'd0);
        $display("txn: FF on full screen, busy %0d cycles", low);

        // reset in the middle of CLEAR
        for (int i = 0; i < 30; i++) sendByte(8'($urandom_range(33, 126)));
        sendByte(CH_LF);
        sendByte(8'h52);
        sendByte(CH_FF);
        repeat (4) driveCycle(1'b0, 8'h00);
        pulseReset();
        countNonBlank(n);
        checkEq("rst_nonblank", 32'(n), 32'd0);
        checkEq("rst_ready", 32'(hostIf.in_ready), 32'd1);
        checkEq("rst_row", 32'(curRow), 32'd0);
        $display("txn: reset during CLEAR, %0d non-blank cells", n);

        // random byte stream
        for (int i = 0; i < 3000; i++) begin
            logic       v;
            logic [7:0] c;
            v = ($urandom_range(0, 9) < 7);
            c = randChar();
            driveCycle(v, c);
            if (v && lastReady) $display("txn: byte 0x%02h -> cursor model (%0d,%0d)", c, mRow, mCol);
        end
        driveCycle(1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
